// File: rtl/sdram_port_master.sv
// rtl/sdram_port_master.sv - SDRAM user-port initiator: round-robin burst requests, ack tracking, frame address stepping
module sdram_port_master #(
  parameter logic [9:0]  BURST      = 10'd512,
  parameter logic [23:0] ADDR_MIN   = 24'd0,
  parameter logic [23:0] ADDR_MAX   = 24'd786432,
  parameter logic [10:0] FIFO_DEPTH = 11'd1024,
  parameter int          RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        wr_load,
  input  logic        rd_load,
  input  logic        rd_enable,
  input  logic [10:0] wr_fifo_level,
  input  logic [10:0] rd_fifo_level,
  output logic        wr_fifo_rd_en,
  output logic        rd_fifo_wr_en,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_wr_addr,
  output logic [9:0]  sdram_wr_burst,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  output logic [23:0] sdram_rd_addr,
  output logic [9:0]  sdram_rd_burst
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_REQ = 3'd1;
  localparam logic [2:0] S_WR_ACK = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_ACK = 3'd4;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  logic [2:0]  state;
  logic [23:0] wr_addr;
  logic [23:0] rd_addr;
  logic        last_grant;
  logic        wr_load_pend;
  logic        rd_load_pend;
  logic        wr_ok;
  logic        rd_ok;
  logic [24:0] wr_addr_inc;
  logic [24:0] rd_addr_inc;
  logic [23:0] wr_addr_step;
  logic [23:0] rd_addr_step;
  logic        rd_push_src;

  // Read room is checked as level + BURST <= depth so an over-full level cannot underflow.
  assign wr_ok = sdram_init_done && (wr_fifo_level >= {1'b0, BURST});
  assign rd_ok = sdram_init_done && rd_enable &&
                 (({1'b0, rd_fifo_level} + {2'b00, BURST}) <= {1'b0, FIFO_DEPTH});

  assign wr_addr_inc  = {1'b0, wr_addr} + {15'd0, BURST};
  assign rd_addr_inc  = {1'b0, rd_addr} + {15'd0, BURST};
  assign wr_addr_step = (wr_addr_inc >= {1'b0, ADDR_MAX}) ? ADDR_MIN : wr_addr_inc[23:0];
  assign rd_addr_step = (rd_addr_inc >= {1'b0, ADDR_MAX}) ? ADDR_MIN : rd_addr_inc[23:0];

  assign sdram_wr_addr  = wr_addr;
  assign sdram_rd_addr  = rd_addr;
  assign sdram_wr_burst = BURST;
  assign sdram_rd_burst = BURST;

  // Strobes only follow acks that belong to a burst this block requested.
  assign wr_fifo_rd_en = sdram_wr_ack && ((state == S_WR_REQ) || (state == S_WR_ACK));
  assign rd_push_src   = sdram_rd_ack && ((state == S_RD_REQ) || (state == S_RD_ACK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_addr      <= ADDR_MIN;
      rd_addr      <= ADDR_MIN;
      last_grant   <= GRANT_RD;
      wr_load_pend <= 1'b0;
      rd_load_pend <= 1'b0;
      sdram_wr_req <= 1'b0;
      sdram_rd_req <= 1'b0;
    end else begin
      if (wr_load && (state != S_WR_ACK)) wr_addr <= ADDR_MIN;
      if (rd_load && (state != S_RD_ACK)) rd_addr <= ADDR_MIN;
      case (state)
        S_IDLE: begin
          if (wr_ok && (!rd_ok || (last_grant == GRANT_RD))) begin
            state        <= S_WR_REQ;
            sdram_wr_req <= 1'b1;
            if (rd_ok) last_grant <= GRANT_WR;
          end else if (rd_ok) begin
            state        <= S_RD_REQ;
            sdram_rd_req <= 1'b1;
            if (wr_ok) last_grant <= GRANT_RD;
          end
        end
        S_WR_REQ: begin
          if (sdram_wr_ack) begin
            sdram_wr_req <= 1'b0;
            wr_load_pend <= wr_load;
            state        <= S_WR_ACK;
          end else if (wr_load) begin
            sdram_wr_req <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_WR_ACK: begin
          if (!sdram_wr_ack) begin
            wr_addr      <= (wr_load_pend || wr_load) ? ADDR_MIN : wr_addr_step;
            wr_load_pend <= 1'b0;
            state        <= S_IDLE;
          end else if (wr_load) begin
            wr_load_pend <= 1'b1;
          end
        end
        S_RD_REQ: begin
          if (sdram_rd_ack) begin
            sdram_rd_req <= 1'b0;
            rd_load_pend <= rd_load;
            state        <= S_RD_ACK;
          end else if (rd_load) begin
            sdram_rd_req <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_RD_ACK: begin
          if (!sdram_rd_ack) begin
            rd_addr      <= (rd_load_pend || rd_load) ? ADDR_MIN : rd_addr_step;
            rd_load_pend <= 1'b0;
            state        <= S_IDLE;
          end else if (rd_load) begin
            rd_load_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  generate
    if (RD_LAT == 0) begin : g_no_lat
      assign rd_fifo_wr_en = rd_push_src;
    end else begin : g_lat
      logic [RD_LAT-1:0] rd_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_pipe <= '0;
        end else begin
          rd_pipe[0] <= rd_push_src;
          for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
      end
      assign rd_fifo_wr_en = rd_pipe[RD_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_sdram_port_master.sv
// tb/tb_sdram_port_master.sv - randomized scoreboard bench for sdram_port_master
module tb_sdram_port_master;

  localparam int BURST_I    = 512;
  localparam int ADDR_MAX_I = 2560;
  localparam int DEPTH_I    = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_init_done = 1'b0;
  logic        wr_load = 1'b0;
  logic        rd_load = 1'b0;
  logic        rd_enable = 1'b0;
  logic [10:0] wr_fifo_level = '0;
  logic [10:0] rd_fifo_level = '0;
  logic        wr_fifo_rd_en;
  logic        rd_fifo_wr_en;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic        sdram_rd_req;
  logic        sdram_rd_ack = 1'b0;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;

  sdram_port_master #(
    .BURST(10'd512), .ADDR_MIN(24'd0), .ADDR_MAX(24'd2560),
    .FIFO_DEPTH(11'd1024), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .wr_load(wr_load), .rd_load(rd_load), .rd_enable(rd_enable),
    .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
    .wr_fifo_rd_en(wr_fifo_rd_en), .rd_fifo_wr_en(rd_fifo_wr_en),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
    .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_rd;
    logic [23:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: frame addresses and the round-robin memory.
  int m_wr_addr = 0;
  int m_rd_addr = 0;
  bit m_last_rd = 1'b1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  function automatic int next_addr(input int a);
    return (a + BURST_I >= ADDR_MAX_I) ? 0 : a + BURST_I;
  endfunction

  function automatic bit model_wr_ok();
    return sdram_init_done && (int'(wr_fifo_level) >= BURST_I);
  endfunction

  function automatic bit model_rd_ok();
    return sdram_init_done && rd_enable && (DEPTH_I - int'(rd_fifo_level) >= BURST_I);
  endfunction

  task automatic predict();
    bit wok, rok, is_rd;
    exp_t e;
    wok = model_wr_ok();
    rok = model_rd_ok();
    if (wok && rok) begin
      is_rd = !m_last_rd;
      m_last_rd = is_rd;
    end else begin
      is_rd = !wok;
    end
    e.is_rd = is_rd;
    if (is_rd) begin
      e.addr = 24'(m_rd_addr);
      m_rd_addr = next_addr(m_rd_addr);
    end else begin
      e.addr = 24'(m_wr_addr);
      m_wr_addr = next_addr(m_wr_addr);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain burst, 1: load pulse mid-ack, 2: reset mid-ack
  task automatic do_burst(input bit last, input int mode);
    int  t;
    bit  got_rd;
    predict();
    t = 0;
    while (!(sdram_wr_req || sdram_rd_req) && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) begin
      check("req_timeout", 0, 1);
      return;
    end
    got_rd = sdram_rd_req;
    repeat ($urandom_range(0, 3)) tick();
    for (int i = 0; i < BURST_I; i++) begin
      if (got_rd) sdram_rd_ack = 1'b1;
      else sdram_wr_ack = 1'b1;
      if (i == 0 && last) begin
        wr_fifo_level = '0;
        rd_enable = 1'b0;
      end
      if (got_rd) rd_load = (mode == 1 && i == 100);
      else wr_load = (mode == 1 && i == 100);
      if (mode == 2 && i == 50) begin
        #2;
        rst_n = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        wr_fifo_level = '0;
        rd_enable = 1'b0;
        #1;
        check("rst_wr_req", sdram_wr_req, 0);
        check("rst_wr_pop", wr_fifo_rd_en, 0);
        check("rst_wr_addr", sdram_wr_addr, 0);
        check("rst_rd_addr", sdram_rd_addr, 0);
        m_wr_addr = 0;
        m_rd_addr = 0;
        m_last_rd = 1'b1;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        return;
      end
      tick();
    end
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    wr_load = 1'b0;
    rd_load = 1'b0;
    if (mode == 1) begin
      if (got_rd) m_rd_addr = 0;
      else m_wr_addr = 0;
    end
  endtask

  // Monitor: request starts against the scoreboard, strobe counts and read latency.
  logic       prev_wr_req = 1'b0, prev_rd_req = 1'b0, prev_wr_ack = 1'b0, prev_push = 1'b0;
  logic [1:0] ack_hist = '0;
  int         wr_cnt = 0, rd_cnt = 0;

  task automatic check_req(input bit is_rd, input logic [23:0] addr);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_req", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("req_kind", is_rd, e.is_rd);
      check(is_rd ? "rd_req_addr" : "wr_req_addr", addr, e.addr);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr_req = 1'b0; prev_rd_req = 1'b0; prev_wr_ack = 1'b0; prev_push = 1'b0;
      ack_hist = '0; wr_cnt = 0; rd_cnt = 0;
    end else begin
      if (sdram_wr_req && !prev_wr_req) check_req(1'b0, sdram_wr_addr);
      if (sdram_rd_req && !prev_rd_req) check_req(1'b1, sdram_rd_addr);
      if (sdram_wr_req && sdram_rd_req) check("req_exclusive", 1, 0);
      wr_cnt += int'(wr_fifo_rd_en);
      if (prev_wr_ack && !sdram_wr_ack) begin
        check("wr_pops", wr_cnt, BURST_I);
        wr_cnt = 0;
      end
      if (rd_fifo_wr_en || ack_hist[1]) check("rd_push_lat", rd_fifo_wr_en, ack_hist[1]);
      rd_cnt += int'(rd_fifo_wr_en);
      if (prev_push && !rd_fifo_wr_en) begin
        check("rd_pushes", rd_cnt, BURST_I);
        rd_cnt = 0;
      end
      ack_hist = {ack_hist[0], sdram_rd_ack};
      prev_wr_req = sdram_wr_req;
      prev_rd_req = sdram_rd_req;
      prev_wr_ack = sdram_wr_ack;
      prev_push   = rd_fifo_wr_en;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard;
    repeat (3) tick();
    check("reset_wr_req", sdram_wr_req, 0);
    check("reset_rd_req", sdram_rd_req, 0);
    check("reset_wr_addr", sdram_wr_addr, 0);
    check("reset_rd_addr", sdram_rd_addr, 0);
    check("reset_push", rd_fifo_wr_en, 0);
    rst_n = 1'b1;
    tick();
    check("wr_burst_const", sdram_wr_burst, BURST_I);
    check("rd_burst_const", sdram_rd_burst, BURST_I);

    // single write burst
    sdram_init_done = 1'b1;
    wr_fifo_level = 11'd512;
    do_burst(1'b1, 0);
    repeat (3) tick();
    check("wr_addr_after_first", sdram_wr_addr, m_wr_addr);

    // both eligible: round-robin
    wr_fifo_level = 11'd600;
    rd_fifo_level = 11'd0;
    rd_enable = 1'b1;
    for (int i = 0; i < 3; i++) do_burst(i == 2, 0);
    repeat (3) tick();

    // randomized phases
    for (int p = 0; p < 10; p++) begin
      sdram_init_done = ($urandom_range(0, 7) != 0);
      wr_fifo_level = 11'($urandom_range(400, 700));
      rd_fifo_level = 11'($urandom_range(350, 650));
      rd_enable = 1'($urandom_range(0, 1));
      if (!model_wr_ok() && !model_rd_ok()) begin
        repeat (30) tick();
      end else begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) do_burst(i == n - 1, 0);
      end
      wr_fifo_level = '0;
      rd_enable = 1'b0;
      repeat (3) tick();
    end
    sdram_init_done = 1'b1;

    // write address wrap at ADDR_MAX
    wr_fifo_level = 11'd600;
    guard = 0;
    while (m_wr_addr != ADDR_MAX_I - BURST_I && guard < 10) begin
      do_burst(1'b0, 0);
      guard++;
    end
    do_burst(1'b1, 0);
    repeat (3) tick();
    check("wr_addr_wrap", sdram_wr_addr, 0);

    // wr_load while idle, then during WR_ACK at address 1024
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    m_wr_addr = 0;
    wr_fifo_level = 11'd600;
    do_burst(1'b0, 0);
    do_burst(1'b0, 0);
    do_burst(1'b1, 1);
    repeat (3) tick();
    check("wr_addr_after_load", sdram_wr_addr, 0);

    // wr_load during WR_REQ aborts the request
    wr_fifo_level = 11'd600;
    predict();
    guard = 0;
    while (!sdram_wr_req && guard < 20) begin
      tick();
      guard++;
    end
    check("abort_req_seen", sdram_wr_req, 1);
    wr_load = 1'b1;
    wr_fifo_level = '0;
    tick();
    wr_load = 1'b0;
    m_wr_addr = 0;
    check("abort_req_drop", sdram_wr_req, 0);
    repeat (20) tick();
    check("abort_no_pop", wr_cnt, 0);
    check("abort_addr", sdram_wr_addr, 0);

    // reset in the middle of a write burst
    wr_fifo_level = 11'd600;
    do_burst(1'b0, 0);
    do_burst(1'b1, 2);
    repeat (3) tick();

    // read room boundary: 424 free words is not enough, 512 is
    sdram_init_done = 1'b1;
    rd_enable = 1'b1;
    rd_fifo_level = 11'd600;
    wr_fifo_level = 11'd511;
    repeat (50) tick();
    check("no_rd_req_room_424", sdram_rd_req, 0);
    check("no_wr_req_level_511", sdram_wr_req, 0);
    rd_fifo_level = 11'd512;
    do_burst(1'b1, 0);
    repeat (5) tick();
    check("rd_addr_after", sdram_rd_addr, m_rd_addr);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
